id_hazard_sb: RTL and testbench

Parametrised operand-forwarding and scoreboard hazard unit for the ID stage. It resolves rs1/rs2 values from a configurable number of forwarding channels or the register file. It tracks in-flight destination registers with per-register latency counters, so it can stall fixed-latency producers (load, mul) and variable-latency producers (div) without a separate load-use flag. It sits between the decoder and the id2ex pipeline register, and drives the ID stall request to the pipeline controller.

---
 rtl/id_hazard_sb_pkg.sv | 20 ++
 rtl/id_hazard_sb_fw_mux.sv | 31 +++
 rtl/id_hazard_sb.sv | 126 ++++++++++++
 tb/tb_id_hazard_sb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_sb_pkg.sv
// Shared constants for the ID-stage hazard/forwarding unit: latency codes,
// the LONG marker and the architectural zero register/value.
package id_hazard_sb_pkg;

  localparam int unsigned XLEN_DEF          = 64;
  localparam int unsigned RF_ADDR_WIDTH_DEF = 5;
  localparam int unsigned LAT_W_DEF         = 3;

  // All-ones latency means "pending until writeback".
  localparam logic [LAT_W_DEF-1:0] LAT_LONG = '1;

  localparam logic [LAT_W_DEF-1:0] LAT_ALU  = 3'd0;
  localparam logic [LAT_W_DEF-1:0] LAT_LOAD = 3'd1;
  localparam logic [LAT_W_DEF-1:0] LAT_MUL  = 3'd3;
  localparam logic [LAT_W_DEF-1:0] LAT_DIV  = LAT_LONG;

  localparam logic [RF_ADDR_WIDTH_DEF-1:0] X0       = '0;
  localparam logic [XLEN_DEF-1:0]          ZEROWORD = '0;

endpackage

// File: rtl/id_hazard_sb_fw_mux.sv
// Priority operand mux: x0 -> zero, else lowest-index matching forwarding
// channel, else register-file read data.
module id_hazard_sb_fw_mux
  import id_hazard_sb_pkg::*;
#(
  parameter int unsigned N_FW          = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned RF_ADDR_WIDTH = 5
) (
  input  logic [RF_ADDR_WIDTH-1:0]      addr_i,
  input  logic [N_FW-1:0]               fw_valid_i,
  input  logic [N_FW*RF_ADDR_WIDTH-1:0] fw_addr_i,
  input  logic [N_FW*XLEN-1:0]          fw_data_i,
  input  logic [XLEN-1:0]               rf_rdata_i,
  output logic [XLEN-1:0]               data_o
);

  // Scan from the oldest channel down so the youngest match is written last.
  always_comb begin
    data_o = rf_rdata_i;
    for (int i = N_FW - 1; i >= 0; i--) begin
      if (fw_valid_i[i] && (fw_addr_i[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == addr_i)) begin
        data_o = fw_data_i[i*XLEN +: XLEN];
      end
    end
    if (addr_i == RF_ADDR_WIDTH'(X0)) begin
      data_o = XLEN'(ZEROWORD);
    end
  end

endmodule

// File: rtl/id_hazard_sb.sv
// ID-stage scoreboard and operand forwarding. Each architectural register
// carries a latency counter; a non-zero counter blocks readers (RAW), and a
// counter exceeding a new producer's latency blocks that writer (WAW).
// LONG (all-ones) counters hold until the matching writeback.
module id_hazard_sb
  import id_hazard_sb_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned N_FW          = 3,
  parameter int unsigned LAT_W         = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [RF_ADDR_WIDTH-1:0]      id_rs1_addr,
  input  logic [RF_ADDR_WIDTH-1:0]      id_rs2_addr,
  input  logic                          id_rs1_used,
  input  logic                          id_rs2_used,
  input  logic                          id_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0]      id_rd_addr,
  input  logic [LAT_W-1:0]              id_lat,
  input  logic                          ex_ready,
  input  logic                          flush,
  input  logic                          wb_valid,
  input  logic [RF_ADDR_WIDTH-1:0]      wb_addr,
  input  logic [N_FW-1:0]               fw_valid,
  input  logic [N_FW*RF_ADDR_WIDTH-1:0] fw_addr,
  input  logic [N_FW*XLEN-1:0]          fw_data,
  input  logic [XLEN-1:0]               rf_rdata1,
  input  logic [XLEN-1:0]               rf_rdata2,
  output logic [XLEN-1:0]               id_rs1,
  output logic [XLEN-1:0]               id_rs2,
  output logic                          id_stall,
  output logic                          id_issue,
  output logic                          sb_busy
);

  localparam int unsigned NREG = 1 << RF_ADDR_WIDTH;
  localparam logic [LAT_W-1:0]         LONG    = '1;
  localparam logic [RF_ADDR_WIDTH-1:0] ADDR_X0 = RF_ADDR_WIDTH'(X0);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  logic raw1, raw2, waw;

  // Hazard detection against the registered counters; flush masks the stall
  // so a squashed instruction never holds the front end.
  always_comb begin
    raw1     = id_valid & id_rs1_used & (id_rs1_addr != ADDR_X0) & (cnt_q[id_rs1_addr] != '0);
    raw2     = id_valid & id_rs2_used & (id_rs2_addr != ADDR_X0) & (cnt_q[id_rs2_addr] != '0);
    waw      = id_valid & id_req_rf   & (id_rd_addr  != ADDR_X0) & (cnt_q[id_rd_addr] > id_lat);
    id_stall = (raw1 | raw2 | waw) & ~flush;
    id_issue = id_valid & ~id_stall & ex_ready & ~flush;
  end

  // Any outstanding producer keeps the scoreboard busy.
  always_comb begin
    sb_busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      sb_busy = sb_busy | (cnt_q[r] != '0);
    end
  end

  // Counter next state: flush, then issue load, then LONG hold/wb clear,
  // then countdown. x0 is pinned to zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (flush) begin
        cnt_d[r] = '0;
      end else if (id_issue && id_req_rf && (id_rd_addr == RF_ADDR_WIDTH'(r))) begin
        cnt_d[r] = id_lat;
      end else if (cnt_q[r] == LONG) begin
        if (wb_valid && (wb_addr == RF_ADDR_WIDTH'(r))) begin
          cnt_d[r] = '0;
        end
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  // Counter array register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  id_hazard_sb_fw_mux #(
    .N_FW          (N_FW),
    .XLEN          (XLEN),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
  ) u_fw_rs1 (
    .addr_i     (id_rs1_addr),
    .fw_valid_i (fw_valid),
    .fw_addr_i  (fw_addr),
    .fw_data_i  (fw_data),
    .rf_rdata_i (rf_rdata1),
    .data_o     (id_rs1)
  );

  id_hazard_sb_fw_mux #(
    .N_FW          (N_FW),
    .XLEN          (XLEN),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
  ) u_fw_rs2 (
    .addr_i     (id_rs2_addr),
    .fw_valid_i (fw_valid),
    .fw_addr_i  (fw_addr),
    .fw_data_i  (fw_data),
    .rf_rdata_i (rf_rdata2),
    .data_o     (id_rs2)
  );

endmodule

// File: tb/tb_id_hazard_sb.sv
// Bench for id_hazard_sb: directed scenarios plus randomized traffic checked
// against a timestamp-based model of register availability.
module tb_id_hazard_sb;
  import id_hazard_sb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_used, id_rs2_used;
  logic        id_req_rf;
  logic [4:0]  id_rd_addr;
  logic [2:0]  id_lat;
  logic        ex_ready, flush, wb_valid;
  logic [4:0]  wb_addr;
  logic [2:0]  fw_valid;
  logic [14:0] fw_addr;
  logic [191:0] fw_data;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic [63:0] id_rs1, id_rs2;
  logic        id_stall, id_issue, sb_busy;

  logic [4:0]  fa [3];
  logic [63:0] fd [3];
  assign fw_addr = {fa[2], fa[1], fa[0]};
  assign fw_data = {fd[2], fd[1], fd[0]};

  id_hazard_sb #(.XLEN(64), .RF_ADDR_WIDTH(5), .N_FW(3), .LAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_req_rf(id_req_rf), .id_rd_addr(id_rd_addr), .id_lat(id_lat),
    .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .fw_valid(fw_valid), .fw_addr(fw_addr), .fw_data(fw_data),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_stall(id_stall), .id_issue(id_issue), .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: a register written with finite latency L at cycle T is readable
  // from cycle T+L+1 (avail); a LONG write is pending until its writeback.
  int now = 0;
  int avail [32];
  bit lng [32];

  function automatic int rem(input int r);
    if (r == 0) return 0;
    if (lng[r]) return 7;
    if (avail[r] > now) return avail[r] - now;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = 0;
    if (id_valid && id_rs1_used && rem(int'(id_rs1_addr)) != 0) h = 1;
    if (id_valid && id_rs2_used && rem(int'(id_rs2_addr)) != 0) h = 1;
    if (id_valid && id_req_rf && rem(int'(id_rd_addr)) > int'(id_lat)) h = 1;
    return h && !flush;
  endfunction

  function automatic bit m_issue();
    return id_valid && !m_stall() && ex_ready && !flush;
  endfunction

  function automatic bit m_busy();
    for (int r = 1; r < 32; r++) if (rem(r) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] m_opnd(input logic [4:0] a, input logic [63:0] rf);
    if (a == 5'd0) return 64'd0;
    for (int i = 0; i < 3; i++) if (fw_valid[i] && fa[i] == a) return fd[i];
    return rf;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin avail[r] = 0; lng[r] = 0; end
  endtask

  // Advance one clock, updating the model from the inputs held this cycle.
  task automatic tick();
    bit iss;
    int rd;
    iss = m_issue();
    rd  = int'(id_rd_addr);
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else begin
      if (wb_valid && lng[wb_addr]) begin lng[wb_addr] = 0; avail[wb_addr] = 0; end
      if (iss && id_req_rf && rd != 0) begin
        lng[rd]   = (id_lat == LAT_DIV);
        avail[rd] = now + int'(id_lat) + 1;
      end
    end
    now++;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_req_rf = 0; id_rd_addr = 0; id_lat = 0; ex_ready = 1; flush = 0;
    wb_valid = 0; wb_addr = 0; fw_valid = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    for (int i = 0; i < 3; i++) begin fa[i] = 0; fd[i] = 0; end
  endtask

  task automatic drive_write(input logic [4:0] rd, input logic [2:0] lat);
    idle();
    id_valid = 1; id_req_rf = 1; id_rd_addr = rd; id_lat = lat;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    n_chk++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", sb_busy); end
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", id_stall); end
    n_chk++; if (id_issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b want 0", id_issue); end
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    drive_write(5'd5, LAT_ALU);
    #1;
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_prod_issue: got %b want 1", id_issue); end
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 5; id_rs1_used = 1; rf_rdata1 = 64'hDEAD;
    fw_valid = 3'b001; fa[0] = 5; fd[0] = 64'h1234;
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", id_stall); end
    n_chk++; if (id_rs1 !== 64'h1234) begin n_fail++; $display("FAIL b2b_rs1: got %h want 1234", id_rs1); end
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_issue: got %b want 1", id_issue); end
    tick();
  endtask

  task automatic test_load_use();
    drive_write(5'd6, LAT_LOAD);
    tick();
    idle();
    id_valid = 1; id_rs2_addr = 6; id_rs2_used = 1; rf_rdata2 = 64'h1;
    #1;
    n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %b want 1", id_stall); end
    n_chk++; if (id_issue !== 1'b0) begin n_fail++; $display("FAIL lu_issue1: got %b want 0", id_issue); end
    tick();
    fw_valid = 3'b010; fa[1] = 6; fd[1] = 64'hABCD_0000_5555_0006;
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %b want 0", id_stall); end
    n_chk++; if (id_rs2 !== 64'hABCD_0000_5555_0006) begin n_fail++; $display("FAIL lu_rs2: got %h want abcd000055550006", id_rs2); end
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL lu_issue2: got %b want 1", id_issue); end
    tick();
  endtask

  task automatic test_div_long();
    drive_write(5'd7, LAT_DIV);
    tick();
    for (int c = 1; c <= 20; c++) begin
      idle();
      id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1;
      if (c == 20) begin wb_valid = 1; wb_addr = 7; end
      #1;
      n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL div_stall c%0d: got %b want 1", c, id_stall); end
      tick();
    end
    idle();
    id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1; rf_rdata1 = 64'h0777_0000_0000_0021;
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL div_release: got %b want 0", id_stall); end
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL div_issue: got %b want 1", id_issue); end
    n_chk++; if (id_rs1 !== 64'h0777_0000_0000_0021) begin n_fail++; $display("FAIL div_rs1: got %h want 0777000000000021", id_rs1); end
    tick();
  endtask

  task automatic test_waw();
    drive_write(5'd8, LAT_DIV);
    tick();
    drive_write(5'd8, LAT_ALU);
    #1;
    n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall1: got %b want 1", id_stall); end
    tick();
    drive_write(5'd9, LAT_ALU);
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL waw_x9_stall: got %b want 0", id_stall); end
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL waw_x9_issue: got %b want 1", id_issue); end
    tick();
    drive_write(5'd8, LAT_ALU);
    wb_valid = 1; wb_addr = 8;
    #1;
    n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall_wb: got %b want 1", id_stall); end
    tick();
    drive_write(5'd8, LAT_ALU);
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL waw_release: got %b want 0", id_stall); end
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL waw_issue: got %b want 1", id_issue); end
    tick();
  endtask

  task automatic test_flush();
    drive_write(5'd7, LAT_DIV);
    tick();
    drive_write(5'd10, LAT_MUL);
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1; flush = 1;
    #1;
    n_chk++; if (sb_busy !== 1'b1) begin n_fail++; $display("FAIL fl_busy_before: got %b want 1", sb_busy); end
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall_gated: got %b want 0", id_stall); end
    n_chk++; if (id_issue !== 1'b0) begin n_fail++; $display("FAIL fl_issue_gated: got %b want 0", id_issue); end
    tick();
    flush = 0;
    #1;
    n_chk++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy_after: got %b want 0", sb_busy); end
    n_chk++; if (id_issue !== 1'b1) begin n_fail++; $display("FAIL fl_dep_issue: got %b want 1", id_issue); end
    tick();
  endtask

  task automatic test_fw_priority();
    idle();
    id_valid = 1; id_rs1_addr = 11; id_rs1_used = 1; rf_rdata1 = 64'hF00D;
    fw_valid = 3'b101; fa[0] = 11; fa[1] = 11; fa[2] = 11;
    fd[0] = 64'hC0C0; fd[1] = 64'hC1C1; fd[2] = 64'hC2C2;
    #1;
    n_chk++; if (id_rs1 !== 64'hC0C0) begin n_fail++; $display("FAIL fwp_ch0: got %h want c0c0", id_rs1); end
    fw_valid = 3'b100;
    #1;
    n_chk++; if (id_rs1 !== 64'hC2C2) begin n_fail++; $display("FAIL fwp_ch2: got %h want c2c2", id_rs1); end
    fw_valid = 3'b000;
    #1;
    n_chk++; if (id_rs1 !== 64'hF00D) begin n_fail++; $display("FAIL fwp_rf: got %h want f00d", id_rs1); end
    id_rs2_addr = 0; id_rs2_used = 1; rf_rdata2 = 64'hBAD;
    fw_valid = 3'b111; fa[0] = 0; fa[1] = 0; fa[2] = 0;
    #1;
    n_chk++; if (id_rs2 !== 64'd0) begin n_fail++; $display("FAIL fwp_x0: got %h want 0", id_rs2); end
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fwp_x0_stall: got %b want 0", id_stall); end
    tick();
  endtask

  task automatic test_ex_not_ready();
    drive_write(5'd12, LAT_MUL);
    ex_ready = 0;
    #1;
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL exr_stall: got %b want 0", id_stall); end
    n_chk++; if (id_issue !== 1'b0) begin n_fail++; $display("FAIL exr_issue: got %b want 0", id_issue); end
    tick();
    idle();
    #1;
    n_chk++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL exr_not_loaded: got %b want 0", sb_busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_req_rf   = 1'($urandom_range(0, 1));
      id_rd_addr  = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: id_lat = LAT_ALU;
        1: id_lat = LAT_LOAD;
        2: id_lat = LAT_MUL;
        3: id_lat = LAT_DIV;
        default: id_lat = 3'($urandom_range(0, 6));
      endcase
      ex_ready  = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      fw_valid  = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        fa[i] = 5'($urandom_range(0, 7));
        fd[i] = {$urandom, $urandom};
      end
      rf_rdata1 = {$urandom, $urandom};
      rf_rdata2 = {$urandom, $urandom};
      #1;
      n_chk++; if (id_stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, id_stall, m_stall()); end
      n_chk++; if (id_issue !== m_issue()) begin n_fail++; $display("FAIL rnd_issue c%0d: got %b want %b", c, id_issue, m_issue()); end
      n_chk++; if (sb_busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, sb_busy, m_busy()); end
      n_chk++; if (id_rs1 !== m_opnd(id_rs1_addr, rf_rdata1)) begin n_fail++; $display("FAIL rnd_rs1 c%0d: got %h want %h", c, id_rs1, m_opnd(id_rs1_addr, rf_rdata1)); end
      n_chk++; if (id_rs2 !== m_opnd(id_rs2_addr, rf_rdata2)) begin n_fail++; $display("FAIL rnd_rs2 c%0d: got %h want %h", c, id_rs2, m_opnd(id_rs2_addr, rf_rdata2)); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive_write(5'd3, LAT_DIV);
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 3; id_rs1_used = 1;
    #1;
    n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL ar_pre_stall: got %b want 1", id_stall); end
    rst_n = 0;
    #1;
    n_chk++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", sb_busy); end
    n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL ar_stall: got %b want 0", id_stall); end
    #1 rst_n = 1;
    model_clear();
    idle();
    tick();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_div_long();
    test_waw();
    test_flush();
    test_fw_priority();
    test_ex_not_ready();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
